// File: rtl/demux_138.sv
// Registered 3-to-8 decoder/demultiplexer with 74x138 enable semantics.
// Latency: 1 cycle from inputs to y, and no combinational input-to-output path.
// Backpressure: none. A new decode is captured on every rising clk edge.
//
// Ports:
//   clk   - system clock; all state changes on its rising edge
//   reset - synchronous reset, active-high; forces y to all ones
//   g1    - enable, active-high
//   g2a   - enable, active-low
//   g2b   - enable, active-low
//   a     - select address, a[0] is the LSB
//   y     - registered decoded outputs, active-low; at most one bit is low
module demux_138 #(
   parameter int SEL_W = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   g1,
   input  logic                   g2a,
   input  logic                   g2b,
   input  logic [SEL_W-1:0]       a,
   output logic [(1<<SEL_W)-1:0]  y
);

   localparam int N = 1 << SEL_W;

   logic         en;
   logic [N-1:0] y_d;
   logic [N-1:0] y_q;

   // Return an all-ones word with only the addressed bit cleared.
   // A disabled decoder returns all ones.
   function automatic logic [N-1:0] decode(input logic enable, input logic [SEL_W-1:0] sel);
      logic [N-1:0] r;
      r = '1;
      if (enable) begin
         r[sel] = 1'b0;
      end
      return r;
   endfunction

   always_comb begin
      en  = g1 & ~g2a & ~g2b;
      y_d = decode(en, a);
   end

   // The register gives glitch-free select lines.
   // Reset takes priority over every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_q <= '1;
      end else begin
         y_q <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: tb/tb_demux_138.sv
// Self-checking bench for demux_138: a directed vector table, a mid-cycle glitch
// sequence, and randomized cycles compared against an arithmetic reference model.
module tb_demux_138;

   logic       clk;
   logic       reset;
   logic       g1;
   logic       g2a;
   logic       g2b;
   logic [2:0] a;
   logic [7:0] y;

   int checks = 0;
   int errors = 0;

   demux_138 #(.SEL_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .g1    (g1),
      .g2a   (g2a),
      .g2b   (g2b),
      .a     (a),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       g1;
      logic       g2a;
      logic       g2b;
      logic [2:0] a;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Reference: reset or any inactive enable gives all ones.
   // Otherwise the output is 255 minus 2**a, so only bit a is low.
   function automatic logic [7:0] ref_y(input logic rst, input logic e1, input logic e2a,
                                        input logic e2b, input logic [2:0] adr);
      int v;
      if (rst || !e1 || e2a || e2b) begin
         v = 255;
      end else begin
         v = 255 - (2 ** int'(adr));
      end
      return 8'(v);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: y=%h expected %h", name, act, exp);
      end
   endtask

   // Drive the inputs at the falling edge, then sample y 1 time unit after the rising edge.
   task automatic apply(input logic rst, input logic e1, input logic e2a,
                        input logic e2b, input logic [2:0] adr);
      @(negedge clk);
      reset = rst;
      g1    = e1;
      g2a   = e2a;
      g2b   = e2b;
      a     = adr;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] prev_exp;
   logic [7:0] exp_v;
   logic       r_rst;
   logic       r_g1;
   logic       r_g2a;
   logic       r_g2b;
   logic [2:0] r_a;

   initial begin
      reset = 1'b1;
      g1    = 1'b0;
      g2a   = 1'b1;
      g2b   = 1'b1;
      a     = 3'd0;

      // Reset held with the decoder enabled, then released.
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'hFF});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'hFF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'hDF});

      // Enables brought active one at a time.
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'hFF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFE});

      // Address sweep with the decoder enabled.
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFE});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'hFD});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hFB});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'hF7});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 8'hEF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'hDF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 8'hBF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 8'h7F});

      // Each enable dropped alone for one cycle, then restored.
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hFB});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'hFF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hFB});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'hFF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hFB});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'hFF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hFB});

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].g1, vecs[i].g2a, vecs[i].g2b, vecs[i].a);
         check($sformatf("vec%0d", i), y, vecs[i].exp);
      end

      // Mid-cycle glitch: the address wanders away and back between edges.
      apply(1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
      check("glitch_base", y, 8'hFD);
      #2 a = 3'd6;
      #1 check("glitch_mid_a6", y, 8'hFD);
      @(negedge clk);
      check("glitch_negedge", y, 8'hFD);
      #2 a = 3'd1;
      @(posedge clk);
      #1 check("glitch_after_edge", y, 8'hFD);

      // Random enables and addresses, with occasional one-cycle reset pulses.
      prev_exp = 8'hFD;
      for (int c = 0; c < 200; c++) begin
         r_rst = ($urandom_range(0, 9) == 0);
         r_g1  = 1'($urandom_range(0, 3) != 0);
         r_g2a = 1'($urandom_range(0, 3) == 0);
         r_g2b = 1'($urandom_range(0, 3) == 0);
         r_a   = 3'($urandom_range(0, 7));
         exp_v = ref_y(r_rst, r_g1, r_g2a, r_g2b, r_a);

         @(negedge clk);
         reset = r_rst;
         g1    = r_g1;
         g2a   = r_g2a;
         g2b   = r_g2b;
         a     = r_a;
         #1 check($sformatf("rnd%0d_hold", c), y, prev_exp);

         @(posedge clk);
         #1;
         check($sformatf("rnd%0d", c), y, exp_v);

         checks++;
         if ($countones(~y) > 1) begin
            errors++;
            $display("FAIL rnd%0d_onehot: y=%h has more than one zero bit", c, y);
         end

         if (r_rst) begin
            check($sformatf("rnd%0d_reset", c), y, 8'hFF);
         end

         prev_exp = exp_v;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: ends the run with a failure if the test stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
